// File: rtl/clkdiv_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg
//   Shared types and constants for the programmable clock divider.
//   - CLKDIV_W        default counter / config field width
//   - IR_38K_*        period-1 and high-time for a 38 kHz carrier at 50 MHz
//   - clkdiv_cfg_t    packed {period, high} configuration word
//   - clkdiv_state_t  divider run state
// ----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int CLKDIV_W      = 16;
  localparam int IR_38K_PERIOD = 1315;
  localparam int IR_38K_HIGH   = 658;

  typedef struct packed {
    logic [CLKDIV_W-1:0] period;
    logic [CLKDIV_W-1:0] high;
  } clkdiv_cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clkdiv_state_t;

endpackage

// File: rtl/clkdiv_cfg_shadow.sv
// ----------------------------------------------------------------------------
// clkdiv_cfg_shadow
//   Holds a configuration accepted while the divider is running until the
//   parent decides it may be applied.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     capture               store period_in/high_in and raise pending
//     load                  parent is consuming the shadow this edge
//     period_in, high_in    configuration offered by the parent
//     pending               a captured config is waiting to be applied
//     cfg_ready             !pending, registered
//     sh_period, sh_high    captured configuration
// ----------------------------------------------------------------------------
module clkdiv_cfg_shadow #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             pending,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] sh_period,
  output logic [WIDTH-1:0] sh_high
);

  logic             pending_q, pending_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;

  // capture is only possible while nothing is pending (cfg_ready gates it),
  // so a capture on the same edge as a load strobe starts a fresh shadow
  // that waits for the next load.
  always_comb begin
    pending_d = pending_q;
    period_d  = period_q;
    high_d    = high_q;
    if (capture) begin
      pending_d = 1'b1;
      period_d  = period_in;
      high_d    = high_in;
    end else if (load) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      pending_q <= pending_d;
      period_q  <= period_d;
      high_q    <= high_d;
    end
  end

  assign pending   = pending_q;
  assign cfg_ready = !pending_q;
  assign sh_period = period_q;
  assign sh_high   = high_q;

endmodule

// File: rtl/prog_clock_divider.sv
// ----------------------------------------------------------------------------
// prog_clock_divider
//   Runtime-programmable clock divider / IR carrier generator. Period and
//   high-time changes made while running are held in a shadow and applied on
//   a period boundary, so the output never glitches.
//   Ports:
//     clk, reset              clock, asynchronous active-high reset
//     en                      run enable
//     cfg_period, cfg_high    new period-1 and high-time
//     cfg_valid / cfg_ready   configuration handshake
//     clk_div                 registered divided waveform
//     tick                    registered pulse on the last cycle of a period
//   Optional (macro PROG_CLKDIV_MOD_EN):
//     mod_in                  modulation data, sampled on period wrap
//     carrier_out             clk_div gated by whole carrier periods
// ----------------------------------------------------------------------------
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH      = CLKDIV_W,
  parameter int DEF_PERIOD = IR_38K_PERIOD,
  parameter int DEF_HIGH   = IR_38K_HIGH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick
`ifdef PROG_CLKDIV_MOD_EN
  ,
  input  logic             mod_in,
  output logic             carrier_out
`endif
);

  clkdiv_state_t    state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;

  logic             accept;
  logic             wrap;
  logic             sh_capture;
  logic             sh_load;
  logic             sh_pending;
  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_high;

  assign accept     = cfg_valid && cfg_ready;
  assign wrap       = (state_q == RUN) && (cnt_q == p_q);
  assign sh_capture = accept && (state_q == RUN);
  // In RUN the shadow drains on a wrap or on the edge leaving RUN. In IDLE
  // it drains on any edge: that only matters when a config was captured on
  // the very edge that left RUN, which would otherwise sit pending forever.
  assign sh_load    = (state_q == RUN) ? (wrap || !en) : 1'b1;

  clkdiv_cfg_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .capture   (sh_capture),
    .load      (sh_load),
    .period_in (cfg_period),
    .high_in   (cfg_high),
    .pending   (sh_pending),
    .cfg_ready (cfg_ready),
    .sh_period (sh_period),
    .sh_high   (sh_high)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    h_d     = h_q;

    // A pending shadow and a direct IDLE accept are mutually exclusive
    // because cfg_ready is low whenever something is pending.
    if (sh_pending && sh_load) begin
      p_d = sh_period;
      h_d = sh_high;
    end else if (accept && (state_q == IDLE)) begin
      p_d = cfg_period;
      h_d = cfg_high;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end
      end
    endcase

    // Outputs describe the count loaded by this edge, judged against the
    // configuration that is in force after the edge.
    clk_div_d = (state_d == RUN) && (cnt_d < h_d);
    tick_d    = (state_d == RUN) && (cnt_d == p_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= WIDTH'(DEF_PERIOD);
      h_q       <= WIDTH'(DEF_HIGH);
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      h_q       <= h_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div = clk_div_q;
  assign tick    = tick_q;

`ifdef PROG_CLKDIV_MOD_EN
  logic gate_q, gate_d;

  // Sampling only on wraps keeps each burst to whole carrier periods.
  always_comb begin
    gate_d = gate_q;
    if (state_d == IDLE) gate_d = 1'b0;
    else if (wrap)       gate_d = mod_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gate_q <= 1'b0;
    else       gate_q <= gate_d;
  end

  assign carrier_out = clk_div_q & gate_q;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// ----------------------------------------------------------------------------
// tb_prog_clock_divider
//   Directed bench for prog_clock_divider. Inputs change and outputs are
//   sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_prog_clock_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_high;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         clk_div;
  logic         tick;
`ifdef PROG_CLKDIV_MOD_EN
  logic         mod_in;
  logic         carrier_out;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  prog_clock_divider dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .clk_div    (clk_div),
    .tick       (tick)
`ifdef PROG_CLKDIV_MOD_EN
    ,
    .mod_in     (mod_in),
    .carrier_out(carrier_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s: got %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples the current cycle, then n-1 more cycles, into bit i of the vectors.
  task automatic capture(input int n, output logic [15:0] cv, output logic [15:0] tv);
    cv = '0;
    tv = '0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) step();
      cv[i] = clk_div;
      tv[i] = tick;
    end
  endtask

  // From IDLE with en already high: one full default period of 1316 cycles.
  task automatic run_default(input string tag);
    int   highs = 0;
    int   ticks = 0;
    int   first_tick = -1;
    logic hi_last = 1'b0;
    logic lo_first = 1'b1;
    for (int i = 0; i < 1316; i++) begin
      step();
      if (clk_div) highs++;
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (i == 657) hi_last = clk_div;
      if (i == 658) lo_first = clk_div;
    end
    check({tag, "_highs"}, highs, 658);
    check({tag, "_tick_idx"}, first_tick, 1315);
    check({tag, "_tick_cnt"}, ticks, 1);
    check({tag, "_hi657"}, {31'd0, hi_last}, 1);
    check({tag, "_lo658"}, {31'd0, lo_first}, 0);
  endtask

  // Leaves RUN, then loads a config in IDLE on the same edge that starts RUN.
  task automatic restart_with(input logic [W-1:0] p, input logic [W-1:0] h);
    en = 1'b0;
    step();
    cfg_period = p;
    cfg_high   = h;
    cfg_valid  = 1'b1;
    en         = 1'b1;
    step();
    cfg_valid  = 1'b0;
  endtask

  logic [15:0] cv, tv;

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_valid  = 1'b0;
`ifdef PROG_CLKDIV_MOD_EN
    mod_in     = 1'b0;
`endif
    #1;
    check("rst_clk_div", {31'd0, clk_div}, 0);
    check("rst_tick", {31'd0, tick}, 0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    step();
    step();
    reset = 1'b0;

    // 1: defaults, 658 high / 658 low, tick at cnt 1315
    en = 1'b1;
    run_default("dflt");

    // 2: IDLE load P=3,H=2, then run
    en = 1'b0;
    step();
    check("idle_clk_div", {31'd0, clk_div}, 0);
    check("idle_tick", {31'd0, tick}, 0);
    cfg_period = 16'd3;
    cfg_high   = 16'd2;
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
    check("idle_accept_ready", {31'd0, cfg_ready}, 1);
    check("idle_still_off", {31'd0, clk_div}, 0);
    en = 1'b1;
    step();
    capture(8, cv, tv);
    check("p3h2_clk", {16'd0, cv}, 32'h33);
    check("p3h2_tick", {16'd0, tv}, 32'h88);

    // 3: change to P=4,H=1 at cnt=1 while running
    step();                       // cnt 0
    step();                       // cnt 1
    check("run_ready_pre", {31'd0, cfg_ready}, 1);
    cfg_period = 16'd4;
    cfg_high   = 16'd1;
    cfg_valid  = 1'b1;
    step();                       // cnt 2, captured in shadow
    cfg_valid  = 1'b0;
    check("run_ready_c2", {31'd0, cfg_ready}, 0);
    check("run_old_c2", {31'd0, clk_div}, 0);
    step();                       // cnt 3, old period ends
    check("run_ready_c3", {31'd0, cfg_ready}, 0);
    check("run_old_tick", {31'd0, tick}, 1);
    step();                       // wrap edge applies new config
    check("run_ready_wrap", {31'd0, cfg_ready}, 1);
    capture(10, cv, tv);
    check("p4h1_clk", {16'd0, cv}, 32'h021);
    check("p4h1_tick", {16'd0, tv}, 32'h210);

    // 4: boundary configs
    restart_with(16'd3, 16'd0);
    capture(8, cv, tv);
    check("h0_clk", {16'd0, cv}, 32'h00);
    check("h0_tick", {16'd0, tv}, 32'h88);
    restart_with(16'd3, 16'd5);
    capture(8, cv, tv);
    check("hgtp_clk", {16'd0, cv}, 32'hFF);
    check("hgtp_tick", {16'd0, tv}, 32'h88);
    restart_with(16'd0, 16'd1);
    capture(8, cv, tv);
    check("p0_clk", {16'd0, cv}, 32'hFF);
    check("p0_tick", {16'd0, tv}, 32'hFF);

`ifdef PROG_CLKDIV_MOD_EN
    // 6: modulation gate switches on whole periods
    restart_with(16'd3, 16'd2);   // cnt 0
    check("mod_c0", {31'd0, carrier_out}, 0);
    step();                       // cnt 1
    mod_in = 1'b1;
    step();                       // cnt 2
    check("mod_c2", {31'd0, carrier_out}, 0);
    step();                       // cnt 3
    check("mod_c3", {31'd0, carrier_out}, 0);
    step();                       // wrap, gate opens
    check("mod_wrap", {31'd0, carrier_out}, 1);
    step();
    check("mod_c1b", {31'd0, carrier_out}, 1);
    step();
    check("mod_c2b", {31'd0, carrier_out}, 0);
    mod_in = 1'b0;
`endif

    // 5: asynchronous reset at cnt=2 with a pending config
    restart_with(16'd3, 16'd3);   // cnt 0
    step();                       // cnt 1
    cfg_period = 16'd7;
    cfg_high   = 16'd7;
    cfg_valid  = 1'b1;
    step();                       // cnt 2, pending
    cfg_valid  = 1'b0;
    check("pre_rst_ready", {31'd0, cfg_ready}, 0);
    check("pre_rst_clk", {31'd0, clk_div}, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_clk_div", {31'd0, clk_div}, 0);
    check("arst_tick", {31'd0, tick}, 0);
    check("arst_ready", {31'd0, cfg_ready}, 1);
    #1;
    reset = 1'b0;
    run_default("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
